// File: rtl/bht_pkg.sv
// Shared types and default sizes for the BHT update controller.
package bht_pkg;

  localparam int unsigned BHT_IDX_W   = 10;
  localparam int unsigned BHT_Q_DEPTH = 4;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } bht_entry_t;

  typedef struct packed {
    logic                 load;
    logic [BHT_IDX_W-1:0] w_idx;
    logic                 taken;
    logic                 correct;
  } bht_update_t;

endpackage

// File: rtl/bht_pred_fifo.sv
// In-order storage for outstanding predictions; full/empty come from count.
module bht_pred_fifo #(
  parameter int unsigned DW    = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/bht_update_ctrl.sv
// Tracks in-flight branch predictions, drives BHT updates and mispredict redirect.
// Optional statistics counters enabled by defining BHT_UPDATE_STATS_EN.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int unsigned width = BHT_IDX_W,
  parameter int unsigned depth = BHT_Q_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pred_valid,
  input  logic [width-1:0]       pred_idx,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_ready,
  input  logic                   flush,
  output logic                   bht_load,
  output logic [width-1:0]       bht_w_idx,
  output logic                   bht_taken,
  output logic                   bht_correct,
  output logic                   mispredict,
  output logic [$clog2(depth):0] count
`ifdef BHT_UPDATE_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  localparam int unsigned CW = $clog2(depth) + 1;

  typedef struct packed {
    logic [width-1:0] idx;
    logic             taken;
  } entry_t;

  entry_t        wr_entry;
  entry_t        head;
  logic [CW-1:0] count_w;
  logic          push_fire, pop_fire, res_correct, squash;

  logic             load_q, load_d;
  logic [width-1:0] w_idx_q, w_idx_d;
  logic             taken_q, taken_d;
  logic             correct_q, correct_d;
  logic             mis_q, mis_d;

  assign pred_ready  = (count_w < CW'(depth));
  assign res_ready   = (count_w != '0);
  assign push_fire   = pred_valid && pred_ready;
  assign pop_fire    = res_valid && res_ready;
  assign res_correct = (head.taken == res_taken);
  assign squash      = flush || (pop_fire && !res_correct);
  assign wr_entry    = '{idx: pred_idx, taken: pred_taken};

  bht_pred_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_fire && !squash),
    .pop     (pop_fire && !squash),
    .clear   (squash),
    .wdata   (wr_entry),
    .rdata_c (head),
    .count   (count_w)
  );

  // Next-state of the registered update/redirect pulse.
  always_comb begin
    load_d    = 1'b0;
    w_idx_d   = '0;
    taken_d   = 1'b0;
    correct_d = 1'b0;
    mis_d     = 1'b0;
    if (pop_fire) begin
      load_d    = 1'b1;
      w_idx_d   = head.idx;
      taken_d   = head.taken;
      correct_d = res_correct;
      mis_d     = !res_correct;
    end
  end

  // Update pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q    <= 1'b0;
      w_idx_q   <= '0;
      taken_q   <= 1'b0;
      correct_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      load_q    <= load_d;
      w_idx_q   <= w_idx_d;
      taken_q   <= taken_d;
      correct_q <= correct_d;
      mis_q     <= mis_d;
    end
  end

  assign bht_load    = load_q;
  assign bht_w_idx   = w_idx_q;
  assign bht_taken   = taken_q;
  assign bht_correct = correct_q;
  assign mispredict  = mis_q;
  assign count       = count_w;

`ifdef BHT_UPDATE_STATS_EN
  logic [31:0] branches_q, branches_d;
  logic [31:0] mispred_q, mispred_d;

  // Saturating resolve and mispredict counters; only reset clears them.
  always_comb begin
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (pop_fire && (branches_q != '1)) branches_d = branches_q + 32'd1;
    if (pop_fire && !res_correct && (mispred_q != '1)) mispred_d = mispred_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispred_q;
`endif

  // Execute must never resolve a branch that was not predicted.
  a_res_when_empty: assert property (@(posedge clk) disable iff (!rst_n) res_valid |-> res_ready)
    else $error("bht_update_ctrl: res_valid with empty queue");

endmodule
